mem_port_arbiter: RTL

Shares a single-ported unified memory between the core's instruction-fetch path and its load/store path. One transaction is outstanding at a time. Data accesses normally win, with a bounded-starvation guarantee for fetch. A fetch-kill input lets a taken branch/jump cancel or discard a fetch. The block sits between the pipeline's IF/MEM stages and the memory; requesters stall while their request is high and the matching `*_rvalid` is low.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store,
// one transaction in flight, data-priority with a bounded fetch starvation window.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {FETCH, DATA} owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic              drop_q;
  logic [SW-1:0]     streak_q;
  logic              mem_req_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic idle, data_win, fetch_win, resp, kill_fetch;

  // Grants are gated by rst_n so nothing is granted while reset is held.
  assign idle       = (state_q == IDLE) && rst_n;
  assign data_win   = idle && d_req && (!if_req || (streak_q < STARVE_LIM));
  assign fetch_win  = idle && !data_win && if_req && !if_kill;
  assign resp       = (state_q == WAIT) && mem_rvalid;
  assign kill_fetch = if_kill && (owner_q == FETCH);

  assign if_gnt    = fetch_win;
  assign d_gnt     = data_win;
  assign if_rvalid = resp && (owner_q == FETCH) && !drop_q && !if_kill;
  assign d_rvalid  = resp && (owner_q == DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= FETCH;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= REQ;
            owner_q     <= DATA;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            mem_addr_q  <= d_addr;
            mem_we_q    <= d_we;
            mem_wdata_q <= d_wdata;
            if (if_req && (streak_q != STARVE_LIM)) streak_q <= streak_q + SW'(1);
          end else if (fetch_win) begin
            state_q     <= REQ;
            owner_q     <= FETCH;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            mem_addr_q  <= if_addr;
            mem_we_q    <= '0;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b0;
            if (kill_fetch) drop_q <= 1'b1;
          end else if (kill_fetch) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
          end else if (kill_fetch) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
